// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the adiabatic adder phase controller.
// Holds the FSM state encoding, the stage/step constants and the queued operand record.
package adder_ctrl_pkg;
    localparam int NUM_STAGES   = 8;
    localparam int CAPTURE_STEP = 8;
    localparam int OP_W         = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EVAL,
        ST_HOLD,
        ST_RECOVER
    } state_t;

    typedef struct packed {
        logic [0:OP_W-1] a;
        logic [0:OP_W-1] b;
        logic            cin;
    } operand_t;
endpackage

// File: rtl/adder_phase_ctrl_op_fifo.sv
// Small operand queue feeding the adder phase controller.
// The caller never pushes when full or pops when empty.
module op_fifo
    import adder_ctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  operand_t wr_data,
    input  logic     pop,
    output operand_t rd_data,
    output logic     full,
    output logic     empty
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    operand_t      mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
endmodule

// File: rtl/adder_phase_ctrl.sv
// Power-clock sequencer for an 8-stage adiabatic adder: queues operands, steps the
// staggered clkpos pulses, captures the sum and holds the last stage under backpressure.
module adder_phase_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:WIDTH-1]      in_a,
    input  logic [0:WIDTH-1]      in_b,
    input  logic                  in_cin,
    output logic [0:NUM_STAGES-1] clkpos,
    output logic [0:NUM_STAGES-1] clkneg,
    output logic [0:WIDTH-1]      op_a,
    output logic [0:WIDTH-1]      op_b,
    output logic                  op_cin,
    input  logic [0:WIDTH-1]      add_out,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:WIDTH-1]      out_sum,
    output logic                  out_cout,
    output logic                  busy,
    output logic [15:0]           ops_done
);
    localparam int SW = $clog2(CAPTURE_STEP + 1);

    state_t                state_q, state_d;
    logic [SW-1:0]         s_q, s_d;
    operand_t              op_q, op_d;
    logic [0:NUM_STAGES-1] clkpos_q, clkpos_d;
    logic                  out_valid_q, out_valid_d;
    logic [0:WIDTH-1]      sum_q, sum_d;
    logic                  cout_q, cout_d;
    logic [15:0]           ops_q, ops_d;
    logic                  push, pop, capture, can_capture;
    logic                  fifo_full, fifo_empty;
    operand_t              push_data, head;

    assign push      = in_valid && in_ready;
    assign push_data = {in_a, in_b, in_cin};

    op_fifo #(.DEPTH(FIFO_DEPTH)) u_op_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (push_data),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        op_d        = op_q;
        pop         = 1'b0;
        capture     = 1'b0;
        can_capture = !out_valid_q || out_ready;
        out_valid_d = out_valid_q && !out_ready;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ops_d       = ops_q;
        clkpos_d    = '0;

        case (state_q)
            ST_IDLE, ST_RECOVER: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    op_d    = head;
                    state_d = ST_EVAL;
                    s_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EVAL: begin
                if (s_q == SW'(CAPTURE_STEP)) begin
                    s_d = '0;
                    if (can_capture) begin
                        capture = 1'b1;
                        state_d = ST_RECOVER;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (can_capture) begin
                    capture = 1'b1;
                    state_d = ST_RECOVER;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A capture overrides any out_ready clear in the same cycle.
        if (capture) begin
            out_valid_d = 1'b1;
            sum_d       = add_out;
            cout_d      = add_cout;
            ops_d       = ops_q + 16'd1;
        end

        // clkpos is registered, so it is decoded from the state being entered.
        for (int i = 0; i < NUM_STAGES; i++) begin
            clkpos_d[i] = (state_d == ST_EVAL) && ((s_d == SW'(i)) || (s_d == SW'(i + 1)));
        end
        if (state_d == ST_HOLD) clkpos_d[NUM_STAGES-1] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            op_q        <= '0;
            clkpos_q    <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            op_q        <= op_d;
            clkpos_q    <= clkpos_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ops_q       <= ops_d;
        end
    end

    assign in_ready  = !fifo_full;
    assign clkpos    = clkpos_q;
    assign clkneg    = ~clkpos_q;
    assign op_a      = op_q.a;
    assign op_b      = op_q.b;
    assign op_cin    = op_q.cin;
    assign out_valid = out_valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign busy      = (state_q != ST_IDLE);
    assign ops_done  = ops_q;
endmodule
